uart_sender: RTL

UART_SENDER -- requirements
Module: uart_sender

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sender_fifo.sv | 62 ++++++
 rtl/uart_sender.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: transmitter state encoding and frame/buffer constants shared by
// the UART sender and its optional byte FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_e;

    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_BITS = 8;

    // Clocks per line bit; integer division truncates toward zero.
    function automatic int calcDiv(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

endpackage

// File: rtl/uart_sender_fifo.sv
// uart_sender_fifo: FIFO_DEPTH-entry byte queue feeding the UART transmitter.
// Only instantiated when UART_SENDER_FIFO_EN is defined. Writes while full and
// reads while empty are ignored; a push and pop in the same cycle keep order.
module uart_sender_fifo
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_wrData,
    input  logic       i_wrEn,
    input  logic       i_rdEn,
    output logic [7:0] o_rdData,
    output logic       o_empty,
    output logic       o_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = i_wrEn && !o_full;
    assign w_rd = i_rdEn && !o_empty;

    // Storage array carries no control state, so it is written without reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count as is.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdData = r_mem[r_rdPtr];
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_FULL);

endmodule

// File: rtl/uart_sender.sv
// uart_sender: 8N1 UART transmitter with a one-byte holding register, or a
// 4-entry FIFO when UART_SENDER_FIFO_EN is defined. The line is driven straight
// from a flop so it never glitches; back-to-back frames leave no idle gap.
module uart_sender
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
)(
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [7:0] in_data,
    input  logic       in_data_en,
    output logic       out_ready,
    output logic       out_busy,
    output logic       uart_tx
);

    localparam int DIV   = calcDiv(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    txState_e              r_state;
    txState_e              w_nextState;
    logic [CNT_W-1:0]      r_baudCnt;
    logic [IDX_W-1:0]      r_bitIdx;
    logic [IDX_W-1:0]      w_bitIdxNext;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_tx;
    logic                  w_txNext;
    logic                  r_rdyEn;
    logic                  w_bitEnd;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_bufEmpty;
    logic                  w_bufFull;
    logic [7:0]            w_bufData;

    assign w_bitEnd  = (r_baudCnt == CNT_LAST);
    assign w_accept  = in_data_en && out_ready;
    assign out_ready = r_rdyEn && !w_bufFull;
    assign out_busy  = (r_state != IDLE) || !w_bufEmpty;
    assign uart_tx   = r_tx;

    // Holds ready low through reset and raises it on the first edge afterwards.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_rdyEn <= 1'b0;
        end else begin
            r_rdyEn <= 1'b1;
        end
    end

`ifdef UART_SENDER_FIFO_EN
    uart_sender_fifo u_fifo (
        .i_clk    (in_clk),
        .i_rst    (in_rst),
        .i_wrData (in_data),
        .i_wrEn   (w_accept),
        .i_rdEn   (w_pop),
        .o_rdData (w_bufData),
        .o_empty  (w_bufEmpty),
        .o_full   (w_bufFull)
    );
`else
    logic       r_holdValid;
    logic [7:0] r_holdData;

    // Single holding register: filled on accept, emptied when the FSM loads the frame.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_holdValid <= 1'b0;
            r_holdData  <= '0;
        end else if (w_accept) begin
            r_holdValid <= 1'b1;
            r_holdData  <= in_data;
        end else if (w_pop) begin
            r_holdValid <= 1'b0;
        end
    end

    assign w_bufData  = r_holdData;
    assign w_bufEmpty = !r_holdValid;
    assign w_bufFull  = r_holdValid;
`endif

    // Transmit FSM state register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a stop bit chains straight into a new start bit when data waits.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (!w_bufEmpty) w_nextState = START;
            START:   if (w_bitEnd) w_nextState = DATA;
            DATA:    if (w_bitEnd && (r_bitIdx == IDX_LAST)) w_nextState = STOP;
            STOP:    if (w_bitEnd) w_nextState = w_bufEmpty ? IDLE : START;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs of the FSM: buffer pop, next bit index and next line level.
    always_comb begin
        w_pop = !w_bufEmpty && ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));

        w_bitIdxNext = r_bitIdx;
        if ((r_state == IDLE) || (r_state == START)) begin
            w_bitIdxNext = '0;
        end else if ((r_state == DATA) && w_bitEnd && (r_bitIdx != IDX_LAST)) begin
            w_bitIdxNext = r_bitIdx + IDX_W'(1);
        end

        w_txNext = 1'b1;
        case (w_nextState)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = r_shift[w_bitIdxNext];
            default: w_txNext = 1'b1;
        endcase
    end

    // Baud counter, bit index, frame shift register and the registered line.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            if ((r_state == IDLE) || w_bitEnd) begin
                r_baudCnt <= '0;
            end else begin
                r_baudCnt <= r_baudCnt + CNT_W'(1);
            end
            r_bitIdx <= w_bitIdxNext;
            if (w_pop) begin
                r_shift <= w_bufData;
            end
            r_tx <= w_txNext;
        end
    end

endmodule
